// File: rtl/accel_sequencer.sv
// accel_sequencer
//   Drives an I2C controller to configure a 3-axis accelerometer once and then
//   poll its six data registers periodically, publishing signed X/Y/Z samples.
//
// Ports
//   clk, rst          : system clock, asynchronous active-high reset
//   enable            : run configuration then periodic polling while high
//   i2c_dev_addr      : device address (constant DEV_ADDR_P)
//   i2c_reg_addr      : register address of the current transaction
//   i2c_r_w           : 1 = read, 0 = write
//   i2c_write_data    : byte written on write transactions
//   i2c_start         : one-cycle transaction request
//   i2c_read_data     : byte returned by a read
//   i2c_done          : controller finished (level, cleared on next start)
//   i2c_ready         : controller idle
//   accel_x/y/z       : signed samples {high byte, low byte}
//   data_valid        : one-cycle pulse when accel_* update
//   configured        : configuration writes completed
//   error             : sticky transaction timeout flag
//   dbg_state         : current FSM state encoding
module accel_sequencer #(
    parameter int         POLL_CYCLES    = 5000000,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [6:0] DEV_ADDR_P     = 7'h1D
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic [6:0]         i2c_dev_addr,
    output logic [7:0]         i2c_reg_addr,
    output logic               i2c_r_w,
    output logic [7:0]         i2c_write_data,
    output logic               i2c_start,
    input  logic [7:0]         i2c_read_data,
    input  logic               i2c_done,
    input  logic               i2c_ready,
    output logic signed [15:0] accel_x,
    output logic signed [15:0] accel_y,
    output logic signed [15:0] accel_z,
    output logic               data_valid,
    output logic               configured,
    output logic               error,
    output logic [3:0]         dbg_state
);

    // A width of at least one bit keeps the counters legal when a parameter is 1.
    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ISSUE     = 4'd1,
        S_WAIT      = 4'd2,
        S_NEXT      = 4'd3,
        S_POLL_WAIT = 4'd4,
        S_PUBLISH   = 4'd5
    } state_t;

    state_t          r_state;
    logic [2:0]      r_step;
    logic [TW-1:0]   r_tmo;
    logic [PW-1:0]   r_poll;
    logic            r_done_q;
    logic [7:0]      r_reg_addr;
    logic            r_r_w;
    logic [7:0]      r_wdata;
    logic [7:0]      r_buf [0:5];
    logic signed [15:0] r_ax;
    logic signed [15:0] r_ay;
    logic signed [15:0] r_az;
    logic            r_valid;
    logic            r_cfg;
    logic            r_err;

    state_t          w_state_nxt;
    logic [2:0]      w_step_nxt;
    logic [2:0]      w_first_step;
    logic [2:0]      w_buf_idx;
    logic            w_done_rise;
    logic            w_capture;
    logic            w_timeout;
    logic            w_set_cfg;
    logic [16:0]     w_cmd;

    // Fixed step list: {r_w, register, write byte}. Steps 2..7 read 0x32..0x37.
    function automatic logic [16:0] step_cmd(input logic [2:0] step);
        case (step)
            3'd0:    return {1'b0, 8'h31, 8'h01};
            3'd1:    return {1'b0, 8'h2D, 8'h08};
            default: return {1'b1, 8'h30 + {5'd0, step}, 8'h00};
        endcase
    endfunction

    // Only a fresh 0->1 transition counts; a done level left over from the
    // previous transaction is ignored until it drops and rises again.
    assign w_done_rise  = i2c_done & ~r_done_q;
    assign w_first_step = r_cfg ? 3'd2 : 3'd0;
    assign w_buf_idx    = r_step - 3'd2;
    assign w_cmd        = step_cmd(w_step_nxt);

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_set_cfg   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_ISSUE;
                    w_step_nxt  = w_first_step;
                end
            end
            S_ISSUE: begin
                if (i2c_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_done_rise) begin
                    w_state_nxt = S_NEXT;
                    w_capture   = r_r_w;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt = S_POLL_WAIT;
                    w_timeout   = 1'b1;
                end
            end
            S_NEXT: begin
                if (r_step == 3'd7) begin
                    w_state_nxt = S_PUBLISH;
                end else begin
                    w_set_cfg   = (r_step == 3'd1);
                    w_step_nxt  = r_step + 3'd1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_POLL_WAIT: begin
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                end else if (r_poll == '0) begin
                    w_state_nxt = S_ISSUE;
                    w_step_nxt  = w_first_step;
                end
            end
            S_PUBLISH: begin
                w_state_nxt = S_POLL_WAIT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_step     <= 3'd0;
            r_tmo      <= '0;
            r_poll     <= '0;
            r_done_q   <= 1'b0;
            r_reg_addr <= 8'h00;
            r_r_w      <= 1'b0;
            r_wdata    <= 8'h00;
            for (int i = 0; i < 6; i++) begin
                r_buf[i] <= 8'h00;
            end
            r_ax       <= '0;
            r_ay       <= '0;
            r_az       <= '0;
            r_valid    <= 1'b0;
            r_cfg      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_step   <= w_step_nxt;
            r_done_q <= i2c_done;

            // Command fields are latched on every cycle headed for ISSUE, so
            // they stay fixed through ISSUE and WAIT.
            if (w_state_nxt == S_ISSUE) begin
                {r_r_w, r_reg_addr, r_wdata} <= w_cmd;
            end

            // Timeout counts WAIT cycles only; a stalled ISSUE never counts.
            if (r_state == S_ISSUE) begin
                r_tmo <= '0;
            end else if (r_state == S_WAIT && !w_done_rise && !w_timeout) begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (w_state_nxt == S_POLL_WAIT && r_state != S_POLL_WAIT) begin
                r_poll <= POLL_LOAD;
            end else if (r_state == S_POLL_WAIT && r_poll != '0) begin
                r_poll <= r_poll - 1'b1;
            end

            if (w_capture) begin
                r_buf[w_buf_idx] <= i2c_read_data;
            end

            if (w_timeout) begin
                r_cfg <= 1'b0;
                r_err <= 1'b1;
            end else if (w_set_cfg) begin
                r_cfg <= 1'b1;
            end

            // All three axes move together, and only after a complete burst.
            r_valid <= (r_state == S_PUBLISH);
            if (r_state == S_PUBLISH) begin
                r_ax <= {r_buf[1], r_buf[0]};
                r_ay <= {r_buf[3], r_buf[2]};
                r_az <= {r_buf[5], r_buf[4]};
            end
        end
    end

    assign i2c_dev_addr   = DEV_ADDR_P;
    assign i2c_reg_addr   = r_reg_addr;
    assign i2c_r_w        = r_r_w;
    assign i2c_write_data = r_wdata;
    assign i2c_start      = (r_state == S_ISSUE) && i2c_ready;
    assign accel_x        = r_ax;
    assign accel_y        = r_ay;
    assign accel_z        = r_az;
    assign data_valid     = r_valid;
    assign configured     = r_cfg;
    assign error          = r_err;
    assign dbg_state      = r_state;

endmodule
